// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer driving the K&S data_path strobes
package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;
endpackage

module control_unit #(
  parameter int RAM_LATENCY = 1,
  parameter bit OV_SIGNED   = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  k_and_s_pkg::decoded_instruction_type decoded_instruction,
  input  logic                                 zero_op,
  input  logic                                 neg_op,
  input  logic                                 unsigned_overflow,
  input  logic                                 signed_overflow,
  output logic                                 branch,
  output logic                                 pc_enable,
  output logic                                 ir_enable,
  output logic                                 addr_sel,
  output logic                                 c_sel,
  output logic [1:0]                           operation,
  output logic                                 write_reg_enable,
  output logic                                 flags_reg_enable,
  output logic                                 ram_write_enable,
  output logic                                 halt,
  output logic [15:0]                          instr_count
);
  import k_and_s_pkg::*;

  localparam int CW = $clog2(RAM_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(RAM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ALU    = 3'd2,
    S_MOVE   = 3'd3,
    S_LOAD   = 3'd4,
    S_STORE  = 3'd5,
    S_BR     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          last_wait;
  logic          retire;
  logic          ov;
  logic          take;

  assign last_wait = (cnt == LAST);
  assign ov        = OV_SIGNED ? signed_overflow : unsigned_overflow;

  // The wait counter restarts on every state change and parks at LAST otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      cnt         <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (cnt != LAST)
        cnt <= cnt + CW'(1);
      if (retire && instr_count != 16'hFFFF)
        instr_count <= instr_count + 16'd1;
    end
  end

  always_comb begin
    take = 1'b0;
    case (decoded_instruction)
      I_BRANCH: take = 1'b1;
      I_BZERO:  take = zero_op;
      I_BNZERO: take = !zero_op;
      I_BNEG:   take = neg_op;
      I_BNNEG:  take = !neg_op;
      I_BOV:    take = ov;
      I_BNOV:   take = !ov;
      default:  take = 1'b0;
    endcase
  end

  always_comb begin
    state_next       = state;
    retire           = 1'b0;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      S_FETCH: begin
        if (last_wait) begin
          ir_enable  = 1'b1;
          pc_enable  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR: state_next = S_ALU;
          I_MOVE:  state_next = S_MOVE;
          I_LOAD:  state_next = S_LOAD;
          I_STORE: state_next = S_STORE;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: state_next = S_BR;
          I_HALT: begin
            state_next = S_HALT;
            retire     = 1'b1;
          end
          default: begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
        endcase
      end
      S_ALU: begin
        case (decoded_instruction)
          I_SUB:   operation = 2'b01;
          I_AND:   operation = 2'b10;
          I_OR:    operation = 2'b11;
          default: operation = 2'b00;
        endcase
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        retire           = 1'b1;
        state_next       = S_FETCH;
      end
      S_MOVE: begin
        // a|a passes the source operand straight through the ALU
        operation        = 2'b11;
        write_reg_enable = 1'b1;
        retire           = 1'b1;
        state_next       = S_FETCH;
      end
      S_LOAD: begin
        addr_sel = 1'b1;
        if (last_wait) begin
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
          retire           = 1'b1;
          state_next       = S_FETCH;
        end
      end
      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        retire           = 1'b1;
        state_next       = S_FETCH;
      end
      S_BR: begin
        pc_enable  = take;
        branch     = take;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: halt = 1'b1;
      default: state_next = S_FETCH;
    endcase
    // Reset must silence the strobes in the same cycle, not at the next edge.
    if (rst) begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = 2'b00;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
      retire           = 1'b0;
    end
  end
endmodule
